xfpga_regs_mc: RTL and testbench
================================

Name: xfpga_regs_mc

Overview:
Second-generation register bank that sits between the crs_master y-bus (y_adr/y_wr_data/y_wr/y_rd_data) and application logic. It is generalised over data width, number of task channels, time-counter width and DPRAM window depth. It adds:
- per-task timeout with sticky status bits;
- atomic multi-word snapshot of the time counter;
- DPRAM page select and done strobe registers.

Parameters:
P_DW, 16, y-bus data width
P_AW, 12, y-bus address width
P_N_TASK, 4, task channels (1..P_DW)
P_LTC_W, 48, time-counter width; must be a multiple of P_DW; N_LTC = P_LTC_W/P_DW words
P_DPRAM_AW, 11, DPRAM window address width; window is y_adr < 2**P_DPRAM_AW; requires P_DPRAM_AW < P_AW
P_TIMEOUT, 1023, cycles a task req may stay high without ack before abort (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
vnum  in  P_DW  version number
y_adr  in  P_AW  bus address
y_wr_data  in  P_DW  bus write data
y_wr  in  1  bus write strobe, 1 cycle
y_rd  in  1  bus read strobe, 1 cycle, coincident with the crs_master sample of y_rd_data
y_rd_data  out  P_DW  bus read data
task_req  out  P_N_TASK  task requests
task_ack  in  P_N_TASK  task acknowledges
ltc_rd_data  in  P_LTC_W  live time counter
ltc_wr_data  out  P_LTC_W  time-counter load value
dpram_page  out  P_DW  DPRAM page/select
dpram_addr  out  P_DPRAM_AW  = y_adr[P_DPRAM_AW-1:0]
dpram_data  out  P_DW  = y_wr_data
dpram_wren  out  1  = y_wr and y_adr < 2**P_DPRAM_AW
dpram_q  in  P_DW  DPRAM read data
dpram_done  out  1  one-cycle done pulse

Interface note: one clock; reset is synchronous and active-high (ports named clk and rst).

Behaviour:
Reset (rst high at a clk edge):
- task_req, timeout status, ltc_wr_data, LTC shadow, dpram_page, dpram_done and all timeout counters go to 0.
- rst overrides any write in the same cycle.
- rst mid-task drops task_req on the next edge; a late ack is then ignored.

Address map (all other addresses decode top-down from max):
- max (0xFFF): vnum, RO.
- max-1: task register.
  - Write: bit i = 1 with task_req[i] = 0 sets task_req[i] next cycle; writes to pending bits are ignored.
  - Read: {0, task_req}.
- max-2: timeout status. Read: sticky bits; write 1 clears the bit.
- max-3: dpram_page, RW.
- max-4: write any value -> dpram_done high for exactly 1 cycle. Read returns 0.
- max-5 down to max-4-N_LTC: LTC words, most significant word at max-5.
  - Read: y_rd at max-5 copies ltc_rd_data into the shadow in the same edge; y_rd_data at max-5 is the live MS word. Lower words read from the shadow. This gives a coherent multi-word read when the MS word is read first.
  - Write: loads the corresponding P_DW slice of ltc_wr_data.
- Addresses below 2**P_DPRAM_AW: y_rd_data = dpram_q.
- Any other address: y_rd_data = 0.
- y_rd_data is combinational on y_adr, except that LTC lower words come from the registered shadow.

Task handshake, per channel i:
- States IDLE (req 0) and BUSY (req 1, counter running).
- IDLE -> BUSY on write bit i; counter cleared.
- BUSY -> IDLE on the edge where task_ack[i] = 1 is sampled; req is low the next cycle.
- Counter increments each BUSY cycle. When it reaches P_TIMEOUT with no ack: req drops, status[i] is set, state goes to IDLE.
- Ack and timeout in the same cycle: ack wins, status is not set.
- Status set and write-1-clear in the same cycle: set wins.
- Ack while IDLE is ignored.
- Channels are fully independent; several can launch in one write.

Simultaneous events:
- y_wr and y_rd are never both high (crs_master guarantee). If both occur anyway, the write takes effect and the read snapshot still occurs.

Test Plan:
- After rst: read max -> vnum (0x1234); read max-1 -> 0x0000; dpram_done = 0; ltc_wr_data = 0.
- Write 0x0005 to max-1 -> task_req = 0b0101 next cycle. Ack ch0 after 3 cycles -> req[0] low next cycle, req[2] still high. Rewrite 0x0004 while ch2 is pending -> no change.
- P_TIMEOUT = 8, no ack on ch1 -> req[1] drops after 8 BUSY cycles; read max-2 -> 0x0002. Write 0x0002 -> reads 0. Ack exactly on the 8th cycle -> status stays 0.
- ltc_rd_data = 0x0001_FFFF_FFFF counting up: read max-5, max-6, max-7 -> 0x0001, 0xFFFF, 0xFFFF, coherent despite rollover to 0x0002_0000_0000 in between.
- Write 0xAAAA/0xBBBB/0xCCCC to max-5..max-7 -> ltc_wr_data = 0xAAAA_BBBB_CCCC. Write max-4 -> single-cycle dpram_done.
- Write 0x0123 at y_adr 0x7FF -> dpram_wren = 1, dpram_addr = 0x7FF. Write at 0x800 -> dpram_wren = 0. Read at 0x900 -> 0x0000.
- Assert rst while ch3 is BUSY -> task_req = 0 next cycle; a late ack causes no change.

Source files
------------

// File: rtl/xfpga_regs_mc.sv
// y-bus register bank: version, task handshakes with timeout, LTC snapshot/load, DPRAM page/done.
// Reads are combinational on y_adr; LTC lower words come from a shadow captured when the MS word is read.
module xfpga_regs_mc #(
  parameter int P_DW       = 16,
  parameter int P_AW       = 12,
  parameter int P_N_TASK   = 4,
  parameter int P_LTC_W    = 48,
  parameter int P_DPRAM_AW = 11,
  parameter int P_TIMEOUT  = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [P_DW-1:0]       vnum,
  input  logic [P_AW-1:0]       y_adr,
  input  logic [P_DW-1:0]       y_wr_data,
  input  logic                  y_wr,
  input  logic                  y_rd,
  output logic [P_DW-1:0]       y_rd_data,
  output logic [P_N_TASK-1:0]   task_req,
  input  logic [P_N_TASK-1:0]   task_ack,
  input  logic [P_LTC_W-1:0]    ltc_rd_data,
  output logic [P_LTC_W-1:0]    ltc_wr_data,
  output logic [P_DW-1:0]       dpram_page,
  output logic [P_DPRAM_AW-1:0] dpram_addr,
  output logic [P_DW-1:0]       dpram_data,
  output logic                  dpram_wren,
  input  logic [P_DW-1:0]       dpram_q,
  output logic                  dpram_done
);

  localparam int N_LTC = P_LTC_W / P_DW;
  localparam int CW    = $clog2(P_TIMEOUT + 1);

  localparam logic [P_AW-1:0] A_VNUM = '1;
  localparam logic [P_AW-1:0] A_TASK = A_VNUM - P_AW'(1);
  localparam logic [P_AW-1:0] A_STAT = A_VNUM - P_AW'(2);
  localparam logic [P_AW-1:0] A_PAGE = A_VNUM - P_AW'(3);
  localparam logic [P_AW-1:0] A_DONE = A_VNUM - P_AW'(4);
  localparam logic [P_AW-1:0] A_LTC0 = A_VNUM - P_AW'(5);

  typedef enum logic {T_IDLE, T_BUSY} tstate_e;

  tstate_e             state_q [P_N_TASK];
  logic [CW-1:0]       cnt_q   [P_N_TASK];
  logic [P_N_TASK-1:0] status_q;
  logic [P_N_TASK-1:0] to_set;
  logic [P_N_TASK-1:0] stat_clr;
  logic [P_DW-1:0]     page_q;
  logic                done_q;
  logic [P_LTC_W-1:0]  ltc_wr_q, ltc_wr_d;
  logic [P_LTC_W-1:0]  shadow_q;
  logic                ltc_lo_hit;
  logic [P_DW-1:0]     ltc_lo_dat;
  logic                in_dpram;

  assign in_dpram   = (y_adr[P_AW-1:P_DPRAM_AW] == '0);
  assign dpram_addr = y_adr[P_DPRAM_AW-1:0];
  assign dpram_data = y_wr_data;
  assign dpram_wren = y_wr && in_dpram;
  assign dpram_page  = page_q;
  assign dpram_done  = done_q;
  assign ltc_wr_data = ltc_wr_q;
  assign stat_clr    = (y_wr && y_adr == A_STAT) ? y_wr_data[P_N_TASK-1:0] : '0;

  // Timeout fires on the P_TIMEOUT-th BUSY cycle unless ack is sampled on that same edge.
  always_comb begin
    for (int i = 0; i < P_N_TASK; i++) begin
      task_req[i] = (state_q[i] == T_BUSY);
      to_set[i]   = (state_q[i] == T_BUSY) && !task_ack[i] && (cnt_q[i] == CW'(P_TIMEOUT - 1));
    end
  end

  always_comb begin
    ltc_wr_d   = ltc_wr_q;
    ltc_lo_hit = 1'b0;
    ltc_lo_dat = '0;
    for (int k = 0; k < N_LTC; k++) begin
      if (y_wr && y_adr == A_LTC0 - P_AW'(k))
        ltc_wr_d[P_LTC_W-1-k*P_DW -: P_DW] = y_wr_data;
      if (k > 0 && y_adr == A_LTC0 - P_AW'(k)) begin
        ltc_lo_hit = 1'b1;
        ltc_lo_dat = shadow_q[P_LTC_W-1-k*P_DW -: P_DW];
      end
    end
  end

  always_comb begin
    y_rd_data = '0;
    if (y_adr == A_VNUM)      y_rd_data = vnum;
    else if (y_adr == A_TASK) y_rd_data[P_N_TASK-1:0] = task_req;
    else if (y_adr == A_STAT) y_rd_data[P_N_TASK-1:0] = status_q;
    else if (y_adr == A_PAGE) y_rd_data = page_q;
    else if (y_adr == A_DONE) y_rd_data = '0;
    else if (y_adr == A_LTC0) y_rd_data = ltc_rd_data[P_LTC_W-1 -: P_DW];
    else if (ltc_lo_hit)      y_rd_data = ltc_lo_dat;
    else if (in_dpram)        y_rd_data = dpram_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < P_N_TASK; i++) begin
        state_q[i] <= T_IDLE;
        cnt_q[i]   <= '0;
      end
      status_q <= '0;
      page_q   <= '0;
      done_q   <= 1'b0;
      ltc_wr_q <= '0;
      shadow_q <= '0;
    end else begin
      for (int i = 0; i < P_N_TASK; i++) begin
        case (state_q[i])
          T_IDLE: if (y_wr && y_adr == A_TASK && y_wr_data[i]) begin
            state_q[i] <= T_BUSY;
            cnt_q[i]   <= '0;
          end
          T_BUSY: begin
            if (task_ack[i] || to_set[i]) state_q[i] <= T_IDLE;
            else                          cnt_q[i]   <= cnt_q[i] + CW'(1);
          end
          default: state_q[i] <= T_IDLE;
        endcase
      end
      // A timeout in the same cycle as a write-1-clear stays set.
      status_q <= (status_q & ~stat_clr) | to_set;
      if (y_wr && y_adr == A_PAGE) page_q <= y_wr_data;
      done_q   <= y_wr && (y_adr == A_DONE);
      ltc_wr_q <= ltc_wr_d;
      if (y_rd && y_adr == A_LTC0) shadow_q <= ltc_rd_data;
    end
  end

endmodule

// File: tb/tb_xfpga_regs_mc.sv
// Directed plus randomized bench for xfpga_regs_mc against a cycle-level behavioural model.
module tb_xfpga_regs_mc;

  localparam int DW = 16, AW = 12, NT = 4, LW = 48, DAW = 11, TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   vnum;
  logic [AW-1:0]   y_adr;
  logic [DW-1:0]   y_wr_data;
  logic            y_wr, y_rd;
  logic [DW-1:0]   y_rd_data;
  logic [NT-1:0]   task_req, task_ack;
  logic [LW-1:0]   ltc_rd_data, ltc_wr_data;
  logic [DW-1:0]   dpram_page, dpram_data, dpram_q;
  logic [DAW-1:0]  dpram_addr;
  logic            dpram_wren, dpram_done;

  always #5 clk = ~clk;

  xfpga_regs_mc #(.P_DW(DW), .P_AW(AW), .P_N_TASK(NT), .P_LTC_W(LW),
                  .P_DPRAM_AW(DAW), .P_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .vnum(vnum), .y_adr(y_adr), .y_wr_data(y_wr_data),
    .y_wr(y_wr), .y_rd(y_rd), .y_rd_data(y_rd_data), .task_req(task_req),
    .task_ack(task_ack), .ltc_rd_data(ltc_rd_data), .ltc_wr_data(ltc_wr_data),
    .dpram_page(dpram_page), .dpram_addr(dpram_addr), .dpram_data(dpram_data),
    .dpram_wren(dpram_wren), .dpram_q(dpram_q), .dpram_done(dpram_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: a task is pending until acked or until its absolute deadline edge.
  logic [NT-1:0] m_req;
  longint        m_deadline [NT];
  logic [NT-1:0] m_status;
  logic [DW-1:0] m_page;
  logic          m_done;
  logic [LW-1:0] m_ltcw, m_shadow;
  longint        cyc;
  logic [DW-1:0] last_rd;
  logic          last_wren;
  logic [DAW-1:0] last_daddr;

  function automatic logic [DW-1:0] exp_rd();
    case (y_adr)
      12'hFFF: return vnum;
      12'hFFE: return {12'h000, m_req};
      12'hFFD: return {12'h000, m_status};
      12'hFFC: return m_page;
      12'hFFB: return 16'h0000;
      12'hFFA: return ltc_rd_data[47:32];
      12'hFF9: return m_shadow[31:16];
      12'hFF8: return m_shadow[15:0];
      default: return (y_adr < 12'h800) ? dpram_q : 16'h0000;
    endcase
  endfunction

  task automatic model_edge();
    logic [NT-1:0] set;
    set = '0;
    if (rst) begin
      m_req = '0; m_status = '0; m_page = '0; m_ltcw = '0; m_shadow = '0;
    end else begin
      for (int i = 0; i < NT; i++) begin
        if (m_req[i]) begin
          if (task_ack[i]) m_req[i] = 1'b0;
          else if (cyc == m_deadline[i]) begin m_req[i] = 1'b0; set[i] = 1'b1; end
        end else if (y_wr && y_adr == 12'hFFE && y_wr_data[i]) begin
          m_req[i] = 1'b1;
          m_deadline[i] = cyc + TO;
        end
      end
      if (y_wr && y_adr == 12'hFFD) m_status = m_status & ~y_wr_data[NT-1:0];
      m_status = m_status | set;
      if (y_wr && y_adr == 12'hFFC) m_page = y_wr_data;
      if (y_wr && y_adr == 12'hFFA) m_ltcw[47:32] = y_wr_data;
      if (y_wr && y_adr == 12'hFF9) m_ltcw[31:16] = y_wr_data;
      if (y_wr && y_adr == 12'hFF8) m_ltcw[15:0]  = y_wr_data;
      if (y_rd && y_adr == 12'hFFA) m_shadow = ltc_rd_data;
    end
    m_done = !rst && y_wr && (y_adr == 12'hFFB);
    cyc++;
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    #4;
    last_rd    = y_rd_data;
    last_wren  = dpram_wren;
    last_daddr = dpram_addr;
    check_eq("rd_data", y_rd_data, exp_rd());
    check_eq("task_req", task_req, m_req);
    check_eq("dpram_done", dpram_done, m_done);
    check_eq("dpram_page", dpram_page, m_page);
    check_eq("ltc_wr_data", ltc_wr_data, m_ltcw);
    check_eq("dpram_wren", dpram_wren, y_wr && (y_adr < 12'h800));
    check_eq("dpram_data", dpram_data, y_wr_data);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    y_adr = a; y_wr_data = d; y_wr = 1'b1; cycle(); y_wr = 1'b0;
  endtask
  task automatic rd(input logic [AW-1:0] a);
    y_adr = a; y_rd = 1'b1; cycle(); y_rd = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) cycle();
  endtask
  task automatic ack(input logic [NT-1:0] m);
    task_ack = m; cycle(); task_ack = '0;
  endtask

  function automatic logic [AW-1:0] pick_adr();
    case ($urandom_range(0, 10))
      0: return 12'hFFF;  1: return 12'hFFE;  2: return 12'hFFD;
      3: return 12'hFFC;  4: return 12'hFFB;  5: return 12'hFFA;
      6: return 12'hFF9;  7: return 12'hFF8;  8: return 12'hFFE;
      9: return AW'($urandom_range(0, 12'h7FF));
      default: return AW'($urandom_range(12'h800, 12'hFF7));
    endcase
  endfunction

  initial begin
    rst = 1'b1; vnum = 16'h1234; y_adr = '0; y_wr_data = '0; y_wr = 1'b0; y_rd = 1'b0;
    task_ack = '0; ltc_rd_data = '0; dpram_q = '0;
    m_req = '0; m_status = '0; m_page = '0; m_done = 1'b0; m_ltcw = '0; m_shadow = '0; cyc = 0;
    for (int i = 0; i < NT; i++) m_deadline[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    rd(12'hFFF);       check_eq("vnum", last_rd, 16'h1234);
    rd(12'hFFE);       check_eq("task_rst", last_rd, 16'h0000);
    check_eq("done_rst", dpram_done, 1'b0);
    check_eq("ltcw_rst", ltc_wr_data, 48'h0);

    wr(12'hFFE, 16'h0005); check_eq("launch", task_req, 4'b0101);
    idle(2);
    ack(4'b0001);      check_eq("ack0", task_req, 4'b0100);
    wr(12'hFFE, 16'h0004); check_eq("rewrite", task_req, 4'b0100);
    ack(4'b0100);      check_eq("ack2", task_req, 4'b0000);

    wr(12'hFFE, 16'h0002);
    idle(7);           check_eq("to_pending", task_req, 4'b0010);
    idle(1);           check_eq("to_drop", task_req, 4'b0000);
    rd(12'hFFD);       check_eq("to_status", last_rd, 16'h0002);
    wr(12'hFFD, 16'h0002);
    rd(12'hFFD);       check_eq("to_clear", last_rd, 16'h0000);
    wr(12'hFFE, 16'h0002);
    idle(7);
    ack(4'b0010);      check_eq("ack_at_to", task_req, 4'b0000);
    rd(12'hFFD);       check_eq("ack_wins", last_rd, 16'h0000);

    ltc_rd_data = 48'h0001_FFFF_FFFF;
    rd(12'hFFA);       check_eq("ltc_ms", last_rd, 16'h0001);
    ltc_rd_data = 48'h0002_0000_0000;
    rd(12'hFF9);       check_eq("ltc_mid", last_rd, 16'hFFFF);
    rd(12'hFF8);       check_eq("ltc_ls", last_rd, 16'hFFFF);

    wr(12'hFFA, 16'hAAAA); wr(12'hFF9, 16'hBBBB); wr(12'hFF8, 16'hCCCC);
    check_eq("ltc_load", ltc_wr_data, 48'hAAAA_BBBB_CCCC);
    wr(12'hFFB, 16'h1111); check_eq("done_pulse", dpram_done, 1'b1);
    idle(1);           check_eq("done_single", dpram_done, 1'b0);

    wr(12'h7FF, 16'h0123); check_eq("wren_in", last_wren, 1'b1);
    check_eq("daddr", last_daddr, 11'h7FF);
    wr(12'h800, 16'h0123); check_eq("wren_out", last_wren, 1'b0);
    dpram_q = 16'h5A5A;
    rd(12'h900);       check_eq("rd_unmapped", last_rd, 16'h0000);
    rd(12'h123);       check_eq("rd_dpram", last_rd, 16'h5A5A);

    wr(12'hFFE, 16'h0008);
    idle(3);
    rst = 1'b1; cycle(); rst = 1'b0;
    check_eq("rst_mid", task_req, 4'b0000);
    ack(4'b1000);      check_eq("late_ack", task_req, 4'b0000);

    for (int n = 0; n < 3000; n++) begin
      int op;
      ltc_rd_data = ltc_rd_data + LW'($urandom_range(0, 3));
      dpram_q = DW'($urandom);
      for (int i = 0; i < NT; i++) task_ack[i] = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      op = $urandom_range(0, 9);
      y_adr = pick_adr();
      y_wr_data = DW'($urandom);
      y_wr = (op <= 2);
      y_rd = (op >= 3 && op <= 5);
      cycle();
      y_wr = 1'b0; y_rd = 1'b0; rst = 1'b0; task_ack = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
